sim_sw_status_mon: RTL and testbench
====================================

# sim_sw_status_mon

Multi-channel software test-status monitor for the Verilator and DV top-levels. Each channel snoops one core's write stream (write-valid, address, low data bits). It decodes writes to that channel's status address into a per-channel state machine and enforces a global cycle watchdog. It then raises registered done/pass/fail/timeout flags that the harness uses to call `$finish` and report the result. It generalises the single-core status interface to N cores, adds fail-fast and timeout handling, and is synthesizable so FPGA builds can expose the flags on LEDs.

## Interface
- NumChannels, 2: number of monitored cores/write streams (1..8).
- AddrWidth, 32: write address width.
- StatusAddrBase, 32'h1000_0000: status address of channel 0.
- ChannelStride, 4: byte offset between consecutive channel status addresses.
- TimeoutWidth, 32: watchdog counter width.
- FailFast, 1: 1 = done as soon as any channel fails or times out; 0 = done only when all channels are terminal.
- clk_i  in  1  monitor clock; single clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- wr_valid_i  in  NumChannels  per-channel write strobe, one cycle per write.
- addr_i  in  NumChannels x AddrWidth  per-channel write address.
- data_i  in  NumChannels x 16  per-channel write data, low 16 bits.
- timeout_cycles_i  in  TimeoutWidth  watchdog limit; 0 disables the watchdog; quasi-static.
- chan_state_o  out  NumChannels x 3  per-channel state encoding.
- last_status_o  out  NumChannels x 16  last accepted status code per channel.
- bad_code_o  out  NumChannels  sticky flag: unknown code written to the status address.
- done_o  out  1  test finished; sticky.
- passed_o  out  1  done and every channel is Passed.
- failed_o  out  1  any channel is Failed.
- timeout_o  out  1  any channel is TimedOut.

## Operation
- Status codes: InBootRom 16'hb090, InTest 16'h4354, InWfi 16'h1d1e, Passed 16'h900d, Failed 16'hbaad.
- Address match for channel c: wr_valid_i[c] && addr_i[c] == StatusAddrBase + c*ChannelStride. All other writes are ignored.
- Per-channel FSM states and encodings: Idle (0), Running (1), Passed (2), Failed (3), TimedOut (4).
  - Idle/Running + InBootRom/InTest/InWfi -> Running.
  - Idle/Running + Passed -> Passed.
  - Idle/Running + Failed -> Failed.
  - Running + watchdog expiry -> TimedOut.
  - Idle channels never time out.
- Passed, Failed and TimedOut are terminal. In a terminal state, matching writes are ignored and last_status_o is frozen.
- Unknown code in Idle/Running: last_status_o updates, bad_code_o sets, the state is unchanged.
- Watchdog counter:
  - Increments by 1 each cycle while at least one channel is Running; holds otherwise.
  - Saturates at all-ones; never clears except on reset.
  - Expiry condition: timeout_cycles_i != 0 && cnt_q >= timeout_cycles_i.
- Simultaneous events:
  - A matching Passed/Failed write in the expiry cycle wins over timeout for that channel.
  - Multiple channels may transition in the same cycle independently.
- done_o:
  - FailFast=1: set when all channels are terminal, or when any channel is Failed/TimedOut.
  - FailFast=0: set only when all channels are terminal.
  - Once set, done_o holds until reset.
- passed_o, failed_o and timeout_o are combinational reductions of the registered channel states. They stay live after done_o.

## Timing
- Reset values:
  - chan_state_o = Idle, last_status_o = 0, bad_code_o = 0.
  - done_o = passed_o = failed_o = timeout_o = 0; watchdog count = 0.
- A write sampled at edge N updates chan_state_o, last_status_o and bad_code_o after edge N.
- done_o rises after edge N+1, one cycle after the terminal state becomes visible, because done is a registered reduction.
- Watchdog: with timeout_cycles_i = T and a first Running entry visible in cycle R, Running channels show TimedOut after edge R+T.
- Reset mid-test: all state clears asynchronously. The first write after rst_ni deasserts is handled normally.

## Structure
- sim_sw_status_pkg holds:
  - the status code localparams;
  - the chan_state_e enum (3-bit);
  - a helper function is_terminal(chan_state_e).
- Sub-module sim_sw_status_chan: one channel's FSM, last_status register and bad_code flag. Inputs: match, data, expire. Instantiated NumChannels times in a generate loop.
- The top level owns the address decode, watchdog counter, done register and flag reductions.

## Test plan
- Two channels: ch0 writes 4354 then 900d, ch1 writes 900d -> both Passed; done_o=1 and passed_o=1 one cycle after the last state change.
- FailFast=1: ch0 writes baad while ch1 is Running -> failed_o=1, done_o=1; ch1 stays Running.
- timeout_cycles_i=100: ch0 writes 4354 and nothing else -> ch0 TimedOut exactly 100 cycles after Running is visible; timeout_o=1, done_o=1.
- In the expiry cycle ch0 writes 900d -> Passed, not TimedOut; after ch1 (Idle) writes 900d, passed_o=1.
- Write 1234 to the ch0 address, then 900d to the ch1 address on ch0's port -> bad_code_o[0]=1, last_status_o[0]=1234, ch0 stays Idle, ch1 unaffected.
- Assert rst_ni low mid-test with ch0 Running and a count of 50 -> all outputs return to reset values immediately; a fresh 900d after release passes normally.

Source files
------------

// File: rtl/sim_sw_status_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sim_sw_status_pkg
// Brief    : Shared status codes, channel state encoding and helpers for the
//            software test-status monitor.
// Revision : 1.0 - initial release
// ============================================================================
package sim_sw_status_pkg;

    // Status codes written by software to its channel's status address
    localparam logic [15:0] c_CODE_BOOT_ROM = 16'hb090;
    localparam logic [15:0] c_CODE_IN_TEST  = 16'h4354;
    localparam logic [15:0] c_CODE_IN_WFI   = 16'h1d1e;
    localparam logic [15:0] c_CODE_PASSED   = 16'h900d;
    localparam logic [15:0] c_CODE_FAILED   = 16'hbaad;

    // Per-channel state; the encoding is visible on chan_state_o
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUNNING   = 3'd1,
        ST_PASSED    = 3'd2,
        ST_FAILED    = 3'd3,
        ST_TIMED_OUT = 3'd4
    } chan_state_e;

    // Terminal states accept no further status writes
    function automatic logic is_terminal(input chan_state_e s);
        return (s == ST_PASSED) || (s == ST_FAILED) || (s == ST_TIMED_OUT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sim_sw_status_chan.sv
`default_nettype none
// ============================================================================
// Module   : sim_sw_status_chan
// Brief    : One monitored channel: status FSM, last accepted status code and
//            sticky unknown-code flag.
// Revision : 1.0 - initial release
// ============================================================================
module sim_sw_status_chan
    import sim_sw_status_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        match_i,
    input  logic [15:0] data_i,
    input  logic        expire_i,
    output chan_state_e state_o,
    output chan_state_e state_next_o,
    output logic [15:0] last_status_o,
    output logic        bad_code_o
);

    chan_state_e r_state;
    chan_state_e w_state_next;
    logic [15:0] r_last_status;
    logic        r_bad_code;
    logic        w_run_code;
    logic        w_accept;
    logic        w_unknown;

    // Next-state decode; a Passed/Failed write beats a same-cycle expiry
    always_comb begin
        w_run_code   = (data_i == c_CODE_BOOT_ROM) || (data_i == c_CODE_IN_TEST) ||
                       (data_i == c_CODE_IN_WFI);
        w_accept     = match_i && !is_terminal(r_state);
        w_unknown    = w_accept && !w_run_code &&
                       (data_i != c_CODE_PASSED) && (data_i != c_CODE_FAILED);
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_RUNNING: begin
                if (match_i && (data_i == c_CODE_PASSED)) begin
                    w_state_next = ST_PASSED;
                end else if (match_i && (data_i == c_CODE_FAILED)) begin
                    w_state_next = ST_FAILED;
                end else if ((r_state == ST_RUNNING) && expire_i) begin
                    w_state_next = ST_TIMED_OUT;
                end else if (match_i && w_run_code) begin
                    w_state_next = ST_RUNNING;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    // State, last status and sticky bad-code registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_IDLE;
            r_last_status <= '0;
            r_bad_code    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_last_status <= data_i;
            end
            if (w_unknown) begin
                r_bad_code <= 1'b1;
            end
        end
    end

    assign state_o       = r_state;
    assign state_next_o  = w_state_next;
    assign last_status_o = r_last_status;
    assign bad_code_o    = r_bad_code;

endmodule
`default_nettype wire

// File: rtl/sim_sw_status_mon.sv
`default_nettype none
// ============================================================================
// Module   : sim_sw_status_mon
// Brief    : Multi-channel software test-status monitor with address decode,
//            global cycle watchdog and sticky done/pass/fail/timeout flags.
// Revision : 1.0 - initial release
// ============================================================================
module sim_sw_status_mon
    import sim_sw_status_pkg::*;
#(
    parameter int                    NUM_CHANNELS     = 2,
    parameter int                    ADDR_WIDTH       = 32,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR_BASE = ADDR_WIDTH'(32'h1000_0000),
    parameter int                    CHANNEL_STRIDE   = 4,
    parameter int                    TIMEOUT_WIDTH    = 32,
    parameter bit                    FAIL_FAST        = 1'b1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NUM_CHANNELS-1:0]                 wr_valid_i,
    input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_CHANNELS-1:0][15:0]           data_i,
    input  logic [TIMEOUT_WIDTH-1:0]                timeout_cycles_i,
    output logic [NUM_CHANNELS-1:0][2:0]            chan_state_o,
    output logic [NUM_CHANNELS-1:0][15:0]           last_status_o,
    output logic [NUM_CHANNELS-1:0]                 bad_code_o,
    output logic                                    done_o,
    output logic                                    passed_o,
    output logic                                    failed_o,
    output logic                                    timeout_o
);

    chan_state_e              w_state      [NUM_CHANNELS];
    chan_state_e              w_state_next [NUM_CHANNELS];
    logic [TIMEOUT_WIDTH-1:0] r_wdog_cnt;
    logic                     r_done;
    logic                     w_expire;
    logic                     w_all_term;
    logic                     w_all_passed;
    logic                     w_any_failed;
    logic                     w_any_timeout;
    logic                     w_any_run_next;
    logic                     w_done_set;

    assign w_expire = (timeout_cycles_i != '0) && (r_wdog_cnt >= timeout_cycles_i);

    generate
        for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
            localparam logic [ADDR_WIDTH-1:0] c_CHAN_ADDR =
                STATUS_ADDR_BASE + ADDR_WIDTH'(g * CHANNEL_STRIDE);

            logic w_match;
            assign w_match = wr_valid_i[g] && (addr_i[g] == c_CHAN_ADDR);

            sim_sw_status_chan u_chan (
                .clk_i         (clk_i),
                .rst_ni        (rst_ni),
                .match_i       (w_match),
                .data_i        (data_i[g]),
                .expire_i      (w_expire),
                .state_o       (w_state[g]),
                .state_next_o  (w_state_next[g]),
                .last_status_o (last_status_o[g]),
                .bad_code_o    (bad_code_o[g])
            );

            assign chan_state_o[g] = w_state[g];
        end
    endgenerate

    // Reductions over the registered channel states
    always_comb begin
        w_all_term     = 1'b1;
        w_all_passed   = 1'b1;
        w_any_failed   = 1'b0;
        w_any_timeout  = 1'b0;
        w_any_run_next = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!is_terminal(w_state[i]))       w_all_term     = 1'b0;
            if (w_state[i] != ST_PASSED)        w_all_passed   = 1'b0;
            if (w_state[i] == ST_FAILED)        w_any_failed   = 1'b1;
            if (w_state[i] == ST_TIMED_OUT)     w_any_timeout  = 1'b1;
            if (w_state_next[i] == ST_RUNNING)  w_any_run_next = 1'b1;
        end
        w_done_set = w_all_term || (FAIL_FAST && (w_any_failed || w_any_timeout));
    end

    // Watchdog: counts cycles spent with a channel Running, including the
    // entry cycle, so expiry lands T cycles after Running becomes visible
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdog_cnt <= '0;
        end else if (w_any_run_next && (r_wdog_cnt != '1)) begin
            r_wdog_cnt <= r_wdog_cnt + TIMEOUT_WIDTH'(1);
        end
    end

    // Sticky done, one cycle behind the terminal states it reduces
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done <= 1'b0;
        end else if (w_done_set) begin
            r_done <= 1'b1;
        end
    end

    assign done_o    = r_done;
    assign passed_o  = r_done && w_all_passed;
    assign failed_o  = w_any_failed;
    assign timeout_o = w_any_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sim_sw_status_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_sw_status_mon
// Brief    : Self-checking bench for sim_sw_status_mon: directed scenarios and
//            randomized write streams against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_sw_status_mon;

    localparam int          N      = 2;
    localparam logic [31:0] A0     = 32'h1000_0000;
    localparam logic [31:0] A1     = 32'h1000_0004;
    localparam int          S_IDLE = 0;
    localparam int          S_RUN  = 1;
    localparam int          S_PASS = 2;
    localparam int          S_FAIL = 3;
    localparam int          S_TMO  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N-1:0]          wr_valid;
    logic [N-1:0][31:0]    addr;
    logic [N-1:0][15:0]    data;
    logic [31:0]           tmo;
    logic [N-1:0][2:0]     chan_state_o;
    logic [N-1:0][15:0]    last_status_o;
    logic [N-1:0]          bad_code_o;
    logic                  done_o, passed_o, failed_o, timeout_o;
    logic [N-1:0][2:0]     state_b;
    logic [N-1:0][15:0]    last_b;
    logic [N-1:0]          badc_b;
    logic                  done_b, passed_b, failed_b, timeout_b;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_state [N];
    logic [15:0] m_last  [N];
    logic        m_bad   [N];
    longint      m_cnt;
    logic        m_done_ff;
    logic        m_done_all;

    always #5 clk = ~clk;

    sim_sw_status_mon #(.NUM_CHANNELS(N), .FAIL_FAST(1'b1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .addr_i(addr),
        .data_i(data), .timeout_cycles_i(tmo), .chan_state_o(chan_state_o),
        .last_status_o(last_status_o), .bad_code_o(bad_code_o), .done_o(done_o),
        .passed_o(passed_o), .failed_o(failed_o), .timeout_o(timeout_o)
    );

    sim_sw_status_mon #(.NUM_CHANNELS(N), .FAIL_FAST(1'b0)) u_dut_all (
        .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .addr_i(addr),
        .data_i(data), .timeout_cycles_i(tmo), .chan_state_o(state_b),
        .last_status_o(last_b), .bad_code_o(badc_b), .done_o(done_b),
        .passed_o(passed_b), .failed_o(failed_b), .timeout_o(timeout_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_state[c] = S_IDLE;
            m_last[c]  = '0;
            m_bad[c]   = 1'b0;
        end
        m_cnt      = 0;
        m_done_ff  = 1'b0;
        m_done_all = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        int ns [N];
        bit all_term = 1'b1;
        bit any_bad  = 1'b0;
        bit any_run  = 1'b0;
        bit expire, match, fin;
        expire = (tmo != 0) && (m_cnt >= longint'(tmo));
        for (int c = 0; c < N; c++) begin
            if (m_state[c] < S_PASS) all_term = 1'b0;
            if (m_state[c] == S_FAIL || m_state[c] == S_TMO) any_bad = 1'b1;
        end
        for (int c = 0; c < N; c++) begin
            ns[c] = m_state[c];
            match = wr_valid[c] && (addr[c] == A0 + 32'(c * 4));
            if (m_state[c] < S_PASS) begin
                fin = match && (data[c] == 16'h900d || data[c] == 16'hbaad);
                if (match) begin
                    m_last[c] = data[c];
                    case (data[c])
                        16'hb090, 16'h4354, 16'h1d1e: ns[c] = S_RUN;
                        16'h900d:                     ns[c] = S_PASS;
                        16'hbaad:                     ns[c] = S_FAIL;
                        default:                      m_bad[c] = 1'b1;
                    endcase
                end
                if (m_state[c] == S_RUN && expire && !fin) ns[c] = S_TMO;
            end
            if (ns[c] == S_RUN) any_run = 1'b1;
        end
        // the watchdog counts every cycle some channel spends Running
        if (any_run && m_cnt < 64'hffff_ffff) m_cnt++;
        if (all_term || any_bad) m_done_ff = 1'b1;
        if (all_term) m_done_all = 1'b1;
        for (int c = 0; c < N; c++) m_state[c] = ns[c];
    endtask

    task automatic compare_all();
        logic [N-1:0][2:0]  es;
        logic [N-1:0][15:0] el;
        logic [N-1:0]       eb;
        bit all_pass = 1'b1;
        bit any_fail = 1'b0;
        bit any_tmo  = 1'b0;
        for (int c = 0; c < N; c++) begin
            es[c] = 3'(m_state[c]);
            el[c] = m_last[c];
            eb[c] = m_bad[c];
            if (m_state[c] != S_PASS) all_pass = 1'b0;
            if (m_state[c] == S_FAIL) any_fail = 1'b1;
            if (m_state[c] == S_TMO)  any_tmo  = 1'b1;
        end
        chk("chan_state",  64'(chan_state_o),  64'(es));
        chk("last_status", 64'(last_status_o), 64'(el));
        chk("bad_code",    64'(bad_code_o),    64'(eb));
        chk("done",        64'(done_o),        64'(m_done_ff));
        chk("passed",      64'(passed_o),      64'(m_done_ff && all_pass));
        chk("failed",      64'(failed_o),      64'(any_fail));
        chk("timeout",     64'(timeout_o),     64'(any_tmo));
        chk("done_all",    64'(done_b),        64'(m_done_all));
        chk("passed_all",  64'(passed_b),      64'(m_done_all && all_pass));
        chk("state_all",   64'(state_b),       64'(es));
    endtask

    task automatic step(input logic [N-1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [15:0] d0, input logic [15:0] d1);
        wr_valid = v;
        addr[0]  = a0;
        addr[1]  = a1;
        data[0]  = d0;
        data[1]  = d1;
        model_step();
        @(posedge clk);
        #1;
        wr_valid = '0;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(2'b00, 32'h0, 32'h0, 16'h0, 16'h0);
    endtask

    task automatic hard_reset(input logic [31:0] t);
        rst_n = 1'b0;
        tmo   = t;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] rand_code();
        int k;
        k = $urandom_range(0, 7);
        case (k)
            0:       return 16'hb090;
            1:       return 16'h4354;
            2:       return 16'h1d1e;
            3:       return 16'h900d;
            4:       return 16'hbaad;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_addr(input int c);
        int k;
        k = $urandom_range(0, 3);
        if (k <= 1) return A0 + 32'(c * 4);
        if (k == 2) return A0 + 32'((1 - c) * 4);
        return $urandom;
    endfunction

    initial begin
        int n;
        logic [N-1:0] v;
        wr_valid = '0;
        addr     = '0;
        data     = '0;
        tmo      = '0;
        model_reset();

        // Reset values
        #12;
        compare_all();
        chk("rst_state", 64'(chan_state_o), 64'(0));
        chk("rst_done",  64'(done_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Both channels pass; done one cycle after the last state change
        step(2'b01, A0, A1, 16'h4354, 16'h0);
        chk("t1_ch0_run", 64'(chan_state_o[0]), 64'(S_RUN));
        step(2'b11, A0, A1, 16'h900d, 16'h900d);
        chk("t1_both_pass", 64'(chan_state_o), 64'({3'd2, 3'd2}));
        chk("t1_done_lag",  64'(done_o), 64'(0));
        idle(1);
        chk("t1_done",   64'(done_o),   64'(1));
        chk("t1_passed", 64'(passed_o), 64'(1));

        // Fail-fast: ch0 fails while ch1 runs
        hard_reset(32'd0);
        step(2'b11, A0, A1, 16'h4354, 16'h4354);
        step(2'b01, A0, A1, 16'hbaad, 16'h0);
        chk("t2_failed", 64'(failed_o), 64'(1));
        idle(1);
        chk("t2_done_ff",  64'(done_o), 64'(1));
        chk("t2_done_all", 64'(done_b), 64'(0));
        chk("t2_ch1_run",  64'(chan_state_o[1]), 64'(S_RUN));

        // Watchdog expiry 100 cycles after Running is visible
        hard_reset(32'd100);
        step(2'b01, A0, A1, 16'h4354, 16'h0);
        n = 0;
        while (chan_state_o[0] != 3'd4 && n < 300) begin
            idle(1);
            n++;
        end
        chk("t3_tmo_latency", 64'(n), 64'(100));
        chk("t3_timeout", 64'(timeout_o), 64'(1));
        idle(1);
        chk("t3_done", 64'(done_o), 64'(1));

        // Passed write in the expiry cycle wins
        hard_reset(32'd100);
        step(2'b01, A0, A1, 16'h4354, 16'h0);
        idle(99);
        step(2'b01, A0, A1, 16'h900d, 16'h0);
        chk("t4_pass_wins", 64'(chan_state_o[0]), 64'(S_PASS));
        idle(3);
        chk("t4_not_yet", 64'(passed_o), 64'(0));
        step(2'b10, A0, A1, 16'h0, 16'h900d);
        idle(1);
        chk("t4_passed", 64'(passed_o), 64'(1));

        // Unknown code and wrong-channel address
        hard_reset(32'd0);
        step(2'b01, A0, A1, 16'h1234, 16'h0);
        step(2'b01, A1, A1, 16'h900d, 16'h0);
        chk("t5_bad0",  64'(bad_code_o[0]),    64'(1));
        chk("t5_last0", 64'(last_status_o[0]), 64'(16'h1234));
        chk("t5_idle0", 64'(chan_state_o[0]),  64'(S_IDLE));
        chk("t5_idle1", 64'(chan_state_o[1]),  64'(S_IDLE));
        chk("t5_last1", 64'(last_status_o[1]), 64'(0));

        // Asynchronous reset mid-test with watchdog count 50
        hard_reset(32'd60);
        step(2'b01, A0, A1, 16'h4354, 16'h0);
        idle(49);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_async_state", 64'(chan_state_o), 64'(0));
        chk("t6_async_last",  64'(last_status_o), 64'(0));
        compare_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b01, A0, A1, 16'h4354, 16'h0);
        idle(30);
        chk("t6_cnt_cleared", 64'(chan_state_o[0]), 64'(S_RUN));
        step(2'b11, A0, A1, 16'h900d, 16'h900d);
        idle(1);
        chk("t6_passed", 64'(passed_o), 64'(1));

        // Randomized write streams against the model
        for (int ep = 0; ep < 6; ep++) begin
            hard_reset((ep % 3 == 0) ? 32'd0 : 32'($urandom_range(5, 40)));
            for (int cyc = 0; cyc < 150; cyc++) begin
                v[0] = ($urandom_range(0, 5) == 0);
                v[1] = ($urandom_range(0, 5) == 0);
                step(v, rand_addr(0), rand_addr(1), rand_code(), rand_code());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
